b10: RTL and testbench

B10 -- requirements
Module: b10

---
 rtl/b10.sv | 173 +++++++++++++++++
 tb/tb_b10.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b10.sv
// rtl/b10.sv - electronic voting terminal: vote capture, remote send/receive handshake, self-test signature
// Outputs cts, ctr and v_out come straight from flops; the FSM computes every next value in one comb block.
module b10 (
  input  logic       clock,
  input  logic       reset,
  input  logic       r_button,
  input  logic       g_button,
  input  logic       key,
  input  logic       start,
  input  logic       test,
  input  logic       rts,
  input  logic       rtr,
  input  logic [3:0] v_in,
  input  logic       __obs,
  output logic       cts,
  output logic       ctr,
  output logic [3:0] v_out
);

  typedef enum logic [3:0] {
    S_STARTUP  = 4'd0,
    S_STANDBY  = 4'd1,
    S_GET_IN   = 4'd2,
    S_START_TX = 4'd3,
    S_SEND     = 4'd4,
    S_TX_2_RX  = 4'd5,
    S_RECEIVE  = 4'd6,
    S_RX_2_TX  = 4'd7,
    S_END_TX   = 4'd8,
    S_TEST_1   = 4'd9,
    S_TEST_2   = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] voto_q, voto_d;
  logic [3:0] sign_q, sign_d;
  logic       last_g_q, last_g_d;
  logic       last_r_q, last_r_d;
  logic       cts_q, cts_d;
  logic       ctr_q, ctr_d;
  logic [3:0] v_out_q, v_out_d;

  // Observation pin is intentionally functionless.
  logic obs_unused;
  assign obs_unused = __obs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_STARTUP;
      voto_q   <= 4'd0;
      sign_q   <= 4'd0;
      last_g_q <= 1'b0;
      last_r_q <= 1'b0;
      cts_q    <= 1'b0;
      ctr_q    <= 1'b0;
      v_out_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      voto_q   <= voto_d;
      sign_q   <= sign_d;
      last_g_q <= last_g_d;
      last_r_q <= last_r_d;
      cts_q    <= cts_d;
      ctr_q    <= ctr_d;
      v_out_q  <= v_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    voto_d   = voto_q;
    sign_d   = sign_q;
    last_g_d = last_g_q;
    last_r_d = last_r_q;
    cts_d    = cts_q;
    ctr_d    = ctr_q;
    v_out_d  = v_out_q;
    case (state_q)
      S_STARTUP: begin
        voto_d = 4'd0;
        cts_d  = 1'b0;
        ctr_d  = 1'b0;
        if (!test) begin
          sign_d  = 4'd0;
          state_d = S_TEST_1;
        end else begin
          state_d = S_STANDBY;
        end
      end
      S_STANDBY: begin
        cts_d = rtr;
        if (start) begin
          voto_d   = 4'd0;
          last_g_d = 1'b0;
          last_r_d = 1'b0;
          state_d  = S_GET_IN;
        end
      end
      S_GET_IN: begin
        if (!start) begin
          state_d = S_START_TX;
        end else if (key) begin
          // Each button press (rising edge) flips its vote bit.
          voto_d[0] = 1'b1;
          if (g_button && !last_g_q) voto_d[1] = ~voto_q[1];
          if (r_button && !last_r_q) voto_d[2] = ~voto_q[2];
          last_g_d = g_button;
          last_r_d = r_button;
        end else begin
          voto_d   = 4'd0;
          last_g_d = 1'b0;
          last_r_d = 1'b0;
        end
      end
      S_START_TX: begin
        voto_d[3] = voto_q[0] & (voto_q[1] ^ voto_q[2]);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (rtr) begin
          v_out_d = voto_q;
          cts_d   = 1'b1;
          state_d = S_TX_2_RX;
        end else begin
          cts_d = 1'b0;
        end
      end
      S_TX_2_RX: begin
        if (!rtr) begin
          cts_d   = 1'b0;
          state_d = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (rts) begin
          voto_d  = v_in;
          ctr_d   = 1'b1;
          state_d = S_RX_2_TX;
        end
      end
      S_RX_2_TX: begin
        if (!rts) begin
          ctr_d   = 1'b0;
          state_d = S_END_TX;
        end
      end
      S_END_TX: begin
        v_out_d = voto_q;
        state_d = S_STANDBY;
      end
      S_TEST_1: begin
        if (rtr) begin
          v_out_d = sign_q;
          cts_d   = 1'b1;
          state_d = S_TEST_2;
        end
      end
      S_TEST_2: begin
        if (!rtr) begin
          cts_d   = 1'b0;
          sign_d  = sign_q + 4'd1;
          state_d = test ? S_STANDBY : S_TEST_1;
        end
      end
      default: state_d = S_STARTUP;
    endcase
  end

  assign cts   = cts_q;
  assign ctr   = ctr_q;
  assign v_out = v_out_q;

endmodule

// File: tb/tb_b10.sv
// tb/tb_b10.sv - self-checking bench for b10 with a press-counting vote model
module tb_b10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       r_button = 1'b0, g_button = 1'b0, key = 1'b0, start = 1'b0;
  logic       test = 1'b1, rts = 1'b0, rtr = 1'b0, obs = 1'b0;
  logic [3:0] v_in = 4'd0;
  logic       cts, ctr;
  logic [3:0] v_out;

  int n_cmp = 0;
  int n_bad = 0;

  b10 dut (
    .clock(clock), .reset(reset), .r_button(r_button), .g_button(g_button),
    .key(key), .start(start), .test(test), .rts(rts), .rtr(rtr),
    .v_in(v_in), .__obs(obs), .cts(cts), .ctr(ctr), .v_out(v_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    obs = $urandom_range(0, 1);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({cts, ctr, v_out} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_async: got cts=%b ctr=%b v_out=%h expected 0 0 0", cts, ctr, v_out);
    end
    tick();
    tick();
    n_cmp++;
    if ({cts, ctr, v_out} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_held: got cts=%b ctr=%b v_out=%h expected 0 0 0", cts, ctr, v_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_standby();
    reset_pulse();
    test = 1'b1;
    rtr  = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (cts !== 1'b1 || ctr !== 1'b0 || v_out !== 4'd0) begin
      n_bad++;
      $display("FAIL standby_cts: got cts=%b ctr=%b v_out=%h expected 1 0 0", cts, ctr, v_out);
    end
    rtr = 1'b0;
    tick();
    n_cmp++;
    if (cts !== 1'b0) begin
      n_bad++;
      $display("FAIL standby_cts_low: got %b expected 0", cts);
    end
  endtask

  // mode 0: one green press, mode 1: both buttons together, mode 2: random activity
  task automatic test_session(input int mode);
    int         g_cnt = 0, r_cnt = 0, n;
    bit         en = 0, pg = 0, pr = 0, k, g, r;
    logic [3:0] exp_v, rx;
    logic [2:0] pat [3];
    n = (mode == 2) ? $urandom_range(1, 12) : 3;
    pat[0] = 3'b100;
    pat[1] = (mode == 0) ? 3'b110 : 3'b111;
    pat[2] = 3'b100;
    start = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (mode == 2) begin
        k = ($urandom_range(0, 3) != 0);
        g = $urandom_range(0, 1);
        r = $urandom_range(0, 1);
      end else begin
        {k, g, r} = pat[i];
      end
      key = k; g_button = g; r_button = r;
      // Model: a key-off cycle discards everything; a press is a button seen high after being low/unknown
      if (!k) begin
        en = 0; g_cnt = 0; r_cnt = 0; pg = 0; pr = 0;
      end else begin
        en = 1;
        if (g && !pg) g_cnt++;
        if (r && !pr) r_cnt++;
        pg = g; pr = r;
      end
      tick();
    end
    exp_v = {en && ((g_cnt % 2) != (r_cnt % 2)), (r_cnt % 2) == 1, (g_cnt % 2) == 1, en};
    start = 1'b0; key = 1'b0; g_button = 1'b0; r_button = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (cts !== 1'b0) begin
      n_bad++;
      $display("FAIL send_wait_cts(mode %0d): got %b expected 0", mode, cts);
    end
    repeat ($urandom_range(0, 3)) tick();
    rtr = 1'b1;
    tick();
    n_cmp++;
    if (v_out !== exp_v || cts !== 1'b1) begin
      n_bad++;
      $display("FAIL send_vote(mode %0d): got v_out=%b cts=%b expected %b 1", mode, v_out, cts, exp_v);
    end
    repeat ($urandom_range(0, 2)) tick();
    rtr = 1'b0;
    tick();
    n_cmp++;
    if (cts !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_release_cts(mode %0d): got %b expected 0", mode, cts);
    end
    rx = (mode == 0) ? 4'hA : 4'($urandom_range(0, 15));
    v_in = rx;
    repeat ($urandom_range(0, 2)) tick();
    rts = 1'b1;
    tick();
    v_in = ~rx;
    n_cmp++;
    if (ctr !== 1'b1 || v_out !== exp_v) begin
      n_bad++;
      $display("FAIL receive_ctr(mode %0d): got ctr=%b v_out=%b expected 1 %b", mode, ctr, v_out, exp_v);
    end
    rts = 1'b0;
    tick();
    n_cmp++;
    if (ctr !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_release_ctr(mode %0d): got %b expected 0", mode, ctr);
    end
    tick();
    n_cmp++;
    if (v_out !== rx) begin
      n_bad++;
      $display("FAIL end_tx_echo(mode %0d): got %h expected %h", mode, v_out, rx);
    end
    rtr = 1'b1;
    tick();
    n_cmp++;
    if (cts !== 1'b1 || v_out !== rx) begin
      n_bad++;
      $display("FAIL back_in_standby(mode %0d): got cts=%b v_out=%h expected 1 %h", mode, cts, v_out, rx);
    end
    rtr = 1'b0;
    tick();
  endtask

  task automatic test_selftest();
    reset_pulse();
    test = 1'b0;
    rtr  = 1'b0;
    tick();
    for (int k = 0; k <= 16; k++) begin
      test = $urandom_range(0, 1);
      rtr = 1'b1;
      tick();
      n_cmp++;
      if (v_out !== 4'(k % 16) || cts !== 1'b1) begin
        n_bad++;
        $display("FAIL selftest_sig[%0d]: got v_out=%h cts=%b expected %h 1", k, v_out, cts, 4'(k % 16));
      end
      test = (k == 16);
      rtr = 1'b0;
      tick();
      n_cmp++;
      if (cts !== 1'b0) begin
        n_bad++;
        $display("FAIL selftest_cts_low[%0d]: got %b expected 0", k, cts);
      end
    end
    rtr = 1'b1;
    tick();
    n_cmp++;
    if (cts !== 1'b1 || v_out !== 4'd0) begin
      n_bad++;
      $display("FAIL selftest_exit: got cts=%b v_out=%h expected 1 0", cts, v_out);
    end
    rtr = 1'b0;
    tick();
  endtask

  task automatic test_async_abort();
    start = 1'b1;
    tick();
    key = 1'b1;
    tick();
    g_button = 1'b1;
    tick();
    g_button = 1'b0;
    tick();
    start = 1'b0; key = 1'b0;
    tick();
    tick();
    rtr = 1'b1;
    tick();
    n_cmp++;
    if (cts !== 1'b1 || v_out !== 4'b1011) begin
      n_bad++;
      $display("FAIL abort_setup: got cts=%b v_out=%b expected 1 1011", cts, v_out);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cts !== 1'b0 || v_out !== 4'd0 || ctr !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_async: got cts=%b ctr=%b v_out=%h expected 0 0 0", cts, ctr, v_out);
    end
    #1;
    reset = 1'b1;
    test = 1'b1;
    rtr = 1'b0;
    tick();
    rtr = 1'b1;
    tick();
    n_cmp++;
    if (cts !== 1'b1 || v_out !== 4'd0) begin
      n_bad++;
      $display("FAIL abort_restart: got cts=%b v_out=%h expected 1 0", cts, v_out);
    end
    rtr = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_standby();
    test_session(0);
    test_session(1);
    for (int i = 0; i < 20; i++) test_session(2);
    test_selftest();
    test_async_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
